// File: rtl/sfx_pkg.sv
// sfx_pkg: shared FSM encodings, default amplitude and requester indices for sfx_scheduler.
package sfx_pkg;
  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_PLAY = 2'd2, S_DONE = 2'd3;
  localparam logic [31:0] DEF_AMPLITUDE = 32'd10000000;
  localparam int SFX_GAMEOVER = 0, SFX_HIT = 1, SFX_SCORE = 2, SFX_MENU = 3;
endpackage

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: latches a half-period delay and produces the registered square-wave sample.
module sfx_tone_gen
  import sfx_pkg::*;
#(
  parameter int DELAY_W = 19,
  parameter logic [31:0] AMPLITUDE = DEF_AMPLITUDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [DELAY_W-1:0] rom_q,
  output logic signed [31:0] sample
);
  logic [DELAY_W-1:0] delay, hp;
  logic snd, hit, snd_n;
  assign hit = delay != '0 && hp == delay - DELAY_W'(1);
  assign snd_n = hit ? ~snd : snd;
  // sample is loaded together with snd so it always reflects the phase of the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay <= '0;
      hp <= '0;
      snd <= 1'b0;
      sample <= '0;
    end else if (load) begin
      delay <= rom_q;
      hp <= '0;
      snd <= 1'b1;
      sample <= rom_q == '0 ? '0 : $signed(AMPLITUDE);
    end else if (run) begin
      hp <= hit || delay == '0 ? '0 : hp + DELAY_W'(1);
      snd <= snd_n;
      sample <= delay == '0 ? '0 : snd_n ? $signed(AMPLITUDE) : -$signed(AMPLITUDE);
    end else begin
      sample <= '0;
    end
  end
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sharing of one tone-ROM square-wave voice between requesters.
// Define SFX_PREEMPT_EN to let a higher-priority pending request cut the current effect short.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 16,
  parameter int DELAY_W = 19,
  parameter int STEP_CYCLES = 400000,
  parameter logic [31:0] AMPLITUDE = DEF_AMPLITUDE,
  parameter logic [NUM_REQ*ADDR_W-1:0] SEG_START = '0,
  parameter logic [NUM_REQ*ADDR_W-1:0] SEG_LEN = '0
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       abort,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         done,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [DELAY_W-1:0]         rom_q,
  output logic signed [31:0]         sample
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int STEP_W = $clog2(STEP_CYCLES);
  state_t state, state_d;
  logic [NUM_REQ-1:0] pending, clr;
  logic [ID_W-1:0] pid;
  logic any, preempt, wrap;
  logic [ADDR_W-1:0] addr, addr_d, rem;
  logic [STEP_W-1:0] step;
  always_comb begin
    pid = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (pending[i]) pid = ID_W'(i);
  end
  assign any = |pending;
  assign clr = state == S_IDLE && any ? NUM_REQ'(1) << pid : '0;
  assign wrap = state == S_PLAY && step == STEP_W'(STEP_CYCLES - 1);
`ifdef SFX_PREEMPT_EN
  logic [NUM_REQ-1:0] hi_mask;
  assign hi_mask = (NUM_REQ'(1) << grant_id) - NUM_REQ'(1);
  assign preempt = |(pending & hi_mask);
`else
  assign preempt = 1'b0;
`endif
  always_comb begin
    state_d = state == S_IDLE ? (any ? S_LOAD : S_IDLE)
            : state == S_LOAD ? (abort || rem == '0 ? S_DONE : S_PLAY)
            : state == S_PLAY ? (abort || preempt || (wrap && rem == ADDR_W'(1)) ? S_DONE
                                 : wrap ? S_LOAD : S_PLAY)
            : S_IDLE;
    addr_d = state == S_IDLE ? (any ? SEG_START[int'(pid)*ADDR_W +: ADDR_W] : addr)
           : state_d == S_DONE ? '0
           : wrap ? addr + ADDR_W'(1) : addr;
  end
  // The ROM sees the next address so its registered q is ready by the end of LOAD
  assign rom_address = addr_d;
  assign busy = state == S_LOAD || state == S_PLAY;
  assign done = state == S_DONE ? NUM_REQ'(1) << grant_id : '0;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pending <= '0;
      grant_id <= '0;
      addr <= '0;
      rem <= '0;
      step <= '0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      pending <= (pending & ~clr) | req;
      if (clr != '0) begin
        grant_id <= pid;
        rem <= SEG_LEN[int'(pid)*ADDR_W +: ADDR_W];
      end
      step <= state == S_PLAY && !wrap ? step + STEP_W'(1) : '0;
      if (wrap) rem <= rem - ADDR_W'(1);
    end
  end
  sfx_tone_gen #(.DELAY_W(DELAY_W), .AMPLITUDE(AMPLITUDE)) u_tone (
    .clk(CLOCK_50),
    .rst(reset),
    .load(state == S_LOAD && state_d == S_PLAY),
    .run(state == S_PLAY && state_d == S_PLAY),
    .rom_q(rom_q),
    .sample(sample)
  );
endmodule
